// File: rtl/load_data_unit.sv
// Load data unit: issues one aligned data-bus read at a time. It then extracts the
// addressed byte, half, word or double from the returned beat and sign- or zero-extends it.
package load_data_unit_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;
endpackage

module load_data_unit
    import load_data_unit_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_addr,
    input  msize_t           in_msize,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    output logic             dreq_valid,
    output logic [63:0]      dreq_addr,
    output msize_t           dreq_size,
    output logic [7:0]       dreq_strobe,
    input  logic             dresp_addr_ok,
    input  logic             dresp_data_ok,
    input  logic [63:0]      dresp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_error,
    output logic [63:0]      out_badaddr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [63:0]        addr_q, addr_d;
    msize_t             msize_q, msize_d;
    logic               uns_q, uns_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [63:0]        out_data_q, out_data_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_error_q, out_error_d;
    logic [63:0]        out_badaddr_q, out_badaddr_d;
    logic               capture;

    // Illegal size encodings are reported as misaligned so they never reach the bus.
    function automatic logic misaligned(input logic [2:0] lo, input msize_t sz);
        logic bad;
        case (sz)
            MSIZE1:  bad = 1'b0;
            MSIZE2:  bad = lo[0];
            MSIZE4:  bad = |lo[1:0];
            MSIZE8:  bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] beat, input logic [2:0] off,
                                            input msize_t sz, input logic uns);
        logic [63:0] raw;
        logic [63:0] res;
        raw = beat >> {off, 3'b000};
        case (sz)
            MSIZE1:  res = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            MSIZE2:  res = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            MSIZE4:  res = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        msize_d       = msize_q;
        uns_d         = uns_q;
        tag_d         = tag_q;
        out_data_d    = out_data_q;
        out_tag_d     = out_tag_q;
        out_error_d   = out_error_q;
        out_badaddr_d = out_badaddr_q;
        capture       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    msize_d = in_msize;
                    uns_d   = in_unsigned;
                    tag_d   = in_tag;
                    if (misaligned(in_addr[2:0], in_msize)) begin
                        out_data_d    = 64'd0;
                        out_tag_d     = in_tag;
                        out_error_d   = 1'b1;
                        out_badaddr_d = in_addr;
                        state_d       = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            out_data_d    = extract(dresp_data, addr_q[2:0], msize_q, uns_q);
            out_tag_d     = tag_q;
            out_error_d   = 1'b0;
            out_badaddr_d = 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= 64'd0;
            msize_q       <= MSIZE1;
            uns_q         <= 1'b0;
            tag_q         <= '0;
            out_data_q    <= 64'd0;
            out_tag_q     <= '0;
            out_error_q   <= 1'b0;
            out_badaddr_q <= 64'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            msize_q       <= msize_d;
            uns_q         <= uns_d;
            tag_q         <= tag_d;
            out_data_q    <= out_data_d;
            out_tag_q     <= out_tag_d;
            out_error_q   <= out_error_d;
            out_badaddr_q <= out_badaddr_d;
        end
    end

    // Bus address/size are forced to zero whenever no request is being presented.
    assign in_ready    = (state_q == S_IDLE);
    assign dreq_valid  = (state_q == S_REQ);
    assign dreq_addr   = dreq_valid ? addr_q : 64'd0;
    assign dreq_size   = dreq_valid ? msize_q : MSIZE1;
    assign dreq_strobe = 8'h00;
    assign out_valid   = (state_q == S_DONE);
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign out_error   = out_error_q;
    assign out_badaddr = out_badaddr_q;

endmodule
